// File: rtl/sha256_sched_ctrl_if.sv
// Handshake and data bundle between the block sources, the scheduler and the
// sha256_w_mem / compression-round datapath.
interface sha256_sched_ctrl_if;
    logic         req0;
    logic         req1;
    logic [511:0] block0;
    logic [511:0] block1;
    logic         core_ready;
    logic [511:0] wm_block;
    logic         wm_init;
    logic         wm_next;
    logic         gnt0;
    logic         gnt1;
    logic         done0;
    logic         done1;
    logic         round_valid;
    logic [5:0]   round_idx;
    logic         round_first;
    logic         round_last;
    logic         busy;
    logic [15:0]  blocks_done;

    // Block sources and the compression datapath drive this side.
    modport master (
        output req0, req1, block0, block1, core_ready,
        input  wm_block, wm_init, wm_next, gnt0, gnt1, done0, done1,
        input  round_valid, round_idx, round_first, round_last, busy, blocks_done
    );

    // The scheduler itself.
    modport slave (
        input  req0, req1, block0, block1, core_ready,
        output wm_block, wm_init, wm_next, gnt0, gnt1, done0, done1,
        output round_valid, round_idx, round_first, round_last, busy, blocks_done
    );
endinterface

// File: rtl/sha256_sched_ctrl.sv
// Round-robin scheduler sharing one sha256_w_mem between two block requesters:
// load the owner's block, step the W memory through 64 rounds under a stall
// handshake, then pulse the owner's done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate pending requests
// LOAD    | wm_init for one cycle, round index cleared
// ROUND   | W word valid for round_idx; advance when core_ready
// DONE    | done pulse to owner, update last_owner and block counter
module sha256_sched_ctrl (
    input  logic                 clk,
    input  logic                 reset,
    sha256_sched_ctrl_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic        owner;
    logic        last_owner;
    logic [5:0]  round_cnt;
    logic [15:0] done_cnt;
    logic        pick;

    // Arbitration: a lone request wins; on a tie the requester not served last wins.
    always_comb begin
        pick = bus.req1;
        if (bus.req0 && bus.req1) begin
            pick = ~last_owner;
        end
    end

    // Sequencer state, owner tracking, round index and completed-block counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            round_cnt  <= 6'd0;
            done_cnt   <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner <= pick;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    round_cnt <= 6'd0;
                    state     <= S_ROUND;
                end
                S_ROUND: begin
                    if (bus.core_ready) begin
                        if (round_cnt == 6'd63) begin
                            state <= S_DONE;
                        end else begin
                            round_cnt <= round_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    last_owner <= owner;
                    done_cnt   <= done_cnt + 16'd1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from state; wm_next follows core_ready combinationally
    // so the W memory steps in the same cycle the datapath consumes the word.
    assign bus.wm_block    = owner ? bus.block1 : bus.block0;
    assign bus.wm_init     = (state == S_LOAD);
    assign bus.round_valid = (state == S_ROUND);
    assign bus.wm_next     = bus.round_valid && bus.core_ready;
    assign bus.round_idx   = round_cnt;
    assign bus.round_first = bus.round_valid && (round_cnt == 6'd0);
    assign bus.round_last  = bus.round_valid && (round_cnt == 6'd63);
    assign bus.busy        = (state != S_IDLE);
    assign bus.gnt0        = bus.busy && !owner;
    assign bus.gnt1        = bus.busy && owner;
    assign bus.done0       = (state == S_DONE) && !owner;
    assign bus.done1       = (state == S_DONE) && owner;
    assign bus.blocks_done = done_cnt;
endmodule
